regbank_wr_arbiter: RTL and testbench

//  Shares the single write port (dest/Din) of the 16x32 RegisterBank between two

---
 rtl/regbank_wr_arbiter.sv | 89 ++++++++
 tb/tb_regbank_wr_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_wr_arbiter.sv
// rtl/regbank_wr_arbiter.sv - round-robin arbiter sharing the RegisterBank write port between ALU and load writeback
// One-entry output stage feeds the bank; hazard outputs expose the staged, not-yet-committed write to decode.

module regbank_wr_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_dest,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_dest,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              hold,
    output logic              wr_en,
    output logic [ADDR_W-1:0] dest,
    output logic [DATA_W-1:0] Din,
    input  logic [ADDR_W-1:0] srcadd1,
    input  logic [ADDR_W-1:0] srcadd2,
    output logic              hazard1,
    output logic              hazard2,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic              s_valid;
    logic [ADDR_W-1:0] s_dest;
    logic [DATA_W-1:0] s_data;
    logic              rr_ptr;

    logic can_load;
    logic grant0;
    logic grant1;
    logic both_valid;

    assign both_valid = req0_valid & req1_valid;
    assign grant0     = req0_valid & (~req1_valid | ~rr_ptr);
    assign grant1     = req1_valid & (~req0_valid |  rr_ptr);

    // The stage can take a new entry when empty or when it drains this cycle.
    assign can_load   = ~s_valid | ~hold;

    // Ready is gated by rst because the valids are not reset-qualified upstream.
    assign req0_ready = ~rst & can_load & grant0;
    assign req1_ready = ~rst & can_load & grant1;

    assign wr_en    = s_valid & ~hold;
    assign dest     = s_dest;
    assign Din      = s_data;
    assign fwd_data = s_data;
    assign hazard1  = s_valid & (s_dest == srcadd1);
    assign hazard2  = s_valid & (s_dest == srcadd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid <= 1'b0;
            s_dest  <= '0;
            s_data  <= '0;
            rr_ptr  <= 1'b0;
        end else if (req0_ready) begin
            s_valid <= 1'b1;
            s_dest  <= req0_dest;
            s_data  <= req0_data;
            rr_ptr  <= 1'b1;
        end else if (req1_ready) begin
            s_valid <= 1'b1;
            s_dest  <= req1_dest;
            s_data  <= req1_data;
            rr_ptr  <= 1'b0;
        end else if (wr_en) begin
            s_valid <= 1'b0;
        end
    end

    // Counts contention cycles regardless of hold; sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (both_valid && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// tb/tb_regbank_wr_arbiter.sv - self-checking bench for regbank_wr_arbiter
// Drives directed scenarios and a randomized run against a transaction-level model.

module tb_regbank_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, hold = 1'b0;
    logic [3:0]  req0_dest = '0, req1_dest = '0, srcadd1 = '0, srcadd2 = '0;
    logic [31:0] req0_data = '0, req1_data = '0;

    logic        r0, r1, wr, h1, h2;
    logic [3:0]  dest;
    logic [31:0] din, fwd;
    logic [15:0] cnt;

    logic        r0_n, r1_n, wr_n, h1_n, h2_n;
    logic [3:0]  dest_n;
    logic [31:0] din_n, fwd_n;
    logic [3:0]  cnt_n;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    regbank_wr_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(r0), .req0_dest(req0_dest), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(r1), .req1_dest(req1_dest), .req1_data(req1_data),
        .hold(hold), .wr_en(wr), .dest(dest), .Din(din),
        .srcadd1(srcadd1), .srcadd2(srcadd2), .hazard1(h1), .hazard2(h2),
        .fwd_data(fwd), .conflict_cnt(cnt)
    );

    regbank_wr_arbiter #(.CNT_W(4)) dut_n (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(r0_n), .req0_dest(req0_dest), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(r1_n), .req1_dest(req1_dest), .req1_data(req1_data),
        .hold(hold), .wr_en(wr_n), .dest(dest_n), .Din(din_n),
        .srcadd1(srcadd1), .srcadd2(srcadd2), .hazard1(h1_n), .hazard2(h2_n),
        .fwd_data(fwd_n), .conflict_cnt(cnt_n)
    );

    // Model: the pending write is a queue of at most one entry; priority is "who goes next".
    typedef struct {
        logic [3:0]  d;
        logic [31:0] v;
    } wr_t;
    wr_t staged[$];
    int  next_pref;
    int  m_cnt, m_cnt4;

    logic        e_r0, e_r1, e_wr, e_h1, e_h2;
    logic [3:0]  e_dest;
    logic [31:0] e_din;
    logic [15:0] e_cnt;
    logic [3:0]  e_cnt4;
    logic [3:0]  last_dest;
    logic [31:0] last_data;

    function automatic void model_reset();
        staged.delete();
        next_pref = 0;
        m_cnt = 0;
        m_cnt4 = 0;
        last_dest = '0;
        last_data = '0;
    endfunction

    function automatic void model_eval();
        int  winner;
        bit  room;
        room = (staged.size() == 0) || !hold;
        if (req0_valid && req1_valid) winner = next_pref;
        else if (req0_valid)          winner = 0;
        else if (req1_valid)          winner = 1;
        else                          winner = -1;
        e_r0   = room && (winner == 0);
        e_r1   = room && (winner == 1);
        e_wr   = (staged.size() != 0) && !hold;
        e_dest = last_dest;
        e_din  = last_data;
        e_h1   = (staged.size() != 0) && (last_dest == srcadd1);
        e_h2   = (staged.size() != 0) && (last_dest == srcadd2);
        e_cnt  = 16'(m_cnt);
        e_cnt4 = 4'(m_cnt4);
    endfunction

    function automatic void model_commit();
        wr_t w;
        if (e_wr) void'(staged.pop_front());
        if (e_r0 || e_r1) begin
            w.d = e_r0 ? req0_dest : req1_dest;
            w.v = e_r0 ? req0_data : req1_data;
            staged.push_back(w);
            last_dest = w.d;
            last_data = w.v;
            next_pref = e_r0 ? 1 : 0;
        end
        if (req0_valid && req1_valid) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
        end
    endfunction

    task automatic sample();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0; hold = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        req0_valid = 1'b1; req1_valid = 1'b1; srcadd1 = 4'd0; srcadd2 = 4'd0;
        #3;
        total_cnt++;
        if ({r0, r1, wr, h1, h2} !== 5'b0) $display("FAIL reset_ctrl got=%b want=00000", {r0, r1, wr, h1, h2});
        else pass_cnt++;
        total_cnt++;
        if ({dest, din, fwd, cnt} !== '0) $display("FAIL reset_data got=%h want=0", {dest, din, fwd, cnt});
        else pass_cnt++;
        total_cnt++;
        if ({r0_n, r1_n, wr_n, cnt_n} !== '0) $display("FAIL reset_narrow got=%h want=0", {r0_n, r1_n, wr_n, cnt_n});
        else pass_cnt++;
        idle_inputs();
        do_reset();
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_dest = 4'd3; req0_data = 32'hDEADBEEF;
        sample();
        total_cnt++;
        if ({r0, r1} !== 2'b10) $display("FAIL single_ready got=%b want=10", {r0, r1});
        else pass_cnt++;
        advance();
        req0_valid = 1'b0;
        sample();
        total_cnt++;
        if ({wr, dest, din} !== {1'b1, 4'd3, 32'hDEADBEEF}) $display("FAIL single_write got=%b/%0d/%h want=1/3/deadbeef", wr, dest, din);
        else pass_cnt++;
        advance();
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd[4];
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_dest = 4'd1; req1_dest = 4'd2;
        req0_data = $urandom; req1_data = $urandom;
        for (int k = 0; k < 4; k++) begin
            sample();
            total_cnt++;
            if ({r0, r1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) $display("FAIL b2b_grant%0d got=%b want=%b", k, {r0, r1}, (k % 2 == 0) ? 2'b10 : 2'b01);
            else pass_cnt++;
            if (k > 0) begin
                total_cnt++;
                if ({wr, din} !== {1'b1, wd[k-1]}) $display("FAIL b2b_write%0d got=%b/%h want=1/%h", k - 1, wr, din, wd[k-1]);
                else pass_cnt++;
            end
            wd[k] = (k % 2 == 0) ? req0_data : req1_data;
            advance();
            if (k % 2 == 0) req0_data = $urandom;
            else            req1_data = $urandom;
        end
        idle_inputs();
        sample();
        total_cnt++;
        if ({wr, din, cnt} !== {1'b1, wd[3], 16'd4}) $display("FAIL b2b_last got=%b/%h/%0d want=1/%h/4", wr, din, cnt, wd[3]);
        else pass_cnt++;
        advance();
        sample();
        total_cnt++;
        if (wr !== 1'b0) $display("FAIL b2b_drain got=%b want=0", wr);
        else pass_cnt++;
        advance();
    endtask

    task automatic test_hold();
        logic [31:0] x, y;
        do_reset();
        x = $urandom; y = $urandom;
        req0_valid = 1'b1; req0_dest = 4'd5; req0_data = x;
        sample();
        advance();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_dest = 4'd8; req1_data = y;
        hold = 1'b1; srcadd1 = 4'd5; srcadd2 = 4'd8;
        for (int k = 0; k < 3; k++) begin
            sample();
            total_cnt++;
            if ({wr, r1, h1, h2, fwd} !== {4'b0010, x}) $display("FAIL hold_cyc%0d got=%b%b%b%b/%h want=0010/%h", k, wr, r1, h1, h2, fwd, x);
            else pass_cnt++;
            advance();
        end
        hold = 1'b0;
        sample();
        total_cnt++;
        if ({wr, dest, din, r1} !== {1'b1, 4'd5, x, 1'b1}) $display("FAIL hold_release got=%b/%0d/%h/%b want=1/5/%h/1", wr, dest, din, r1, x);
        else pass_cnt++;
        advance();
        req1_valid = 1'b0;
        sample();
        total_cnt++;
        if ({wr, dest, din, h1, h2} !== {1'b1, 4'd8, y, 2'b01}) $display("FAIL hold_next got=%b/%0d/%h/%b%b want=1/8/%h/01", wr, dest, din, h1, h2, y);
        else pass_cnt++;
        advance();
    endtask

    task automatic test_same_dest();
        logic [31:0] a, b, first, second;
        bit w0;
        a = $urandom; b = a ^ 32'h5A5A_0001;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_dest = 4'd7; req1_dest = 4'd7; req0_data = a; req1_data = b;
        sample();
        total_cnt++;
        if ({r0, r1} !== {e_r0, e_r1} || (r0 ^ r1) !== 1'b1) $display("FAIL waw_grant got=%b want=%b", {r0, r1}, {e_r0, e_r1});
        else pass_cnt++;
        w0 = e_r0;
        first = w0 ? a : b; second = w0 ? b : a;
        advance();
        if (w0) req0_valid = 1'b0; else req1_valid = 1'b0;
        sample();
        total_cnt++;
        if ({wr, dest, din, r0 | r1} !== {1'b1, 4'd7, first, 1'b1}) $display("FAIL waw_first got=%b/%0d/%h/%b want=1/7/%h/1", wr, dest, din, r0 | r1, first);
        else pass_cnt++;
        advance();
        idle_inputs();
        sample();
        total_cnt++;
        if ({wr, dest, din} !== {1'b1, 4'd7, second}) $display("FAIL waw_second got=%b/%0d/%h want=1/7/%h", wr, dest, din, second);
        else pass_cnt++;
        advance();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req0_valid = 1'b1; req0_dest = 4'd9; req0_data = $urandom;
        sample();
        advance();
        req0_valid = 1'b1; req1_valid = 1'b1; srcadd1 = 4'd9;
        rst = 1'b1;
        model_reset();
        #1;
        total_cnt++;
        if ({wr, h1, r0, r1, dest, din, cnt} !== '0) $display("FAIL rst_async got=%b%b%b%b/%0d/%h/%0d want=0", wr, h1, r0, r1, dest, din, cnt);
        else pass_cnt++;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample();
            total_cnt++;
            if (wr !== 1'b0) $display("FAIL rst_nowrite%0d got=%b want=0", k, wr);
            else pass_cnt++;
            advance();
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        sample();
        total_cnt++;
        if ({r0, r1} !== 2'b10) $display("FAIL rst_prio got=%b want=10", {r0, r1});
        else pass_cnt++;
        advance();
        idle_inputs();
        sample();
        advance();
    endtask

    task automatic test_saturate();
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1; hold = 1'b1;
        for (int k = 0; k < 20; k++) begin
            sample();
            total_cnt++;
            if ({cnt, cnt_n} !== {e_cnt, e_cnt4}) $display("FAIL sat_cyc%0d got=%0d/%0d want=%0d/%0d", k, cnt, cnt_n, e_cnt, e_cnt4);
            else pass_cnt++;
            advance();
        end
        idle_inputs();
        sample();
        total_cnt++;
        if ({cnt_n, cnt} !== {4'hF, 16'd20}) $display("FAIL sat_final got=%h/%0d want=f/20", cnt_n, cnt);
        else pass_cnt++;
        advance();
    endtask

    task automatic test_random();
        bit p0 = 0, p1 = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (!p0 && $urandom_range(0, 99) < 60) begin
                p0 = 1; req0_dest = 4'($urandom); req0_data = $urandom;
            end
            if (!p1 && $urandom_range(0, 99) < 50) begin
                p1 = 1; req1_dest = 4'($urandom); req1_data = $urandom;
            end
            req0_valid = p0; req1_valid = p1;
            hold = ($urandom_range(0, 99) < 25);
            srcadd1 = ($urandom_range(0, 1) == 1) ? last_dest : 4'($urandom);
            srcadd2 = 4'($urandom);
            sample();
            total_cnt++;
            if ({r0, r1, wr, h1, h2} !== {e_r0, e_r1, e_wr, e_h1, e_h2})
                $display("FAIL rnd_ctrl%0d got=%b want=%b", c, {r0, r1, wr, h1, h2}, {e_r0, e_r1, e_wr, e_h1, e_h2});
            else pass_cnt++;
            total_cnt++;
            if ({dest, din, fwd, cnt} !== {e_dest, e_din, e_din, e_cnt})
                $display("FAIL rnd_data%0d got=%0d/%h/%h/%0d want=%0d/%h/%h/%0d", c, dest, din, fwd, cnt, e_dest, e_din, e_din, e_cnt);
            else pass_cnt++;
            total_cnt++;
            if ({r0_n, r1_n, wr_n, dest_n, din_n, h1_n, h2_n, fwd_n, cnt_n} !== {e_r0, e_r1, e_wr, e_dest, e_din, e_h1, e_h2, e_din, e_cnt4})
                $display("FAIL rnd_narrow%0d got=%b/%0d/%h/%0d want=%b/%0d/%h/%0d", c, {r0_n, r1_n, wr_n, h1_n, h2_n}, dest_n, din_n, cnt_n, {e_r0, e_r1, e_wr, e_h1, e_h2}, e_dest, e_din, e_cnt4);
            else pass_cnt++;
            advance();
            if (e_r0) p0 = 0;
            if (e_r1) p1 = 0;
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_same_dest();
        test_reset_midflight();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
